// File: rtl/cpu_arb_pkg.sv
// Shared types for the memory port arbiter: FSM state encoding and the
// grant encoding produced by the winner-selection block.
package cpu_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GNT_IF = 2'd1,
    ST_GNT_D  = 2'd2,
    ST_ACK    = 2'd3
  } arb_state_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_IF   = 2'd1,
    GNT_D    = 2'd2
  } gnt_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection between the fetch port and the load/store port.
// With MEM_ARB_RR_EN defined, ties alternate through a one-bit pointer that
// remembers which side was served last; otherwise data always beats fetch.
module mem_arb_pick
  import cpu_arb_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic if_req,
  input  logic d_req,
  input  logic take,
  output gnt_t pick
);

  logic prefer_d;

`ifdef MEM_ARB_RR_EN
  // Pointer flips toward the side that was not just granted; reset favours data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prefer_d <= 1'b1;
    end else if (take) begin
      prefer_d <= (pick == GNT_IF);
    end
  end
`else
  logic unused_pick;
  assign prefer_d    = 1'b1;
  assign unused_pick = ^{clk, rst_n, take};
`endif

  // Tie-break only matters when both sides ask in the same cycle.
  always_comb begin
    pick = GNT_NONE;
    if (d_req && (!if_req || prefer_d)) begin
      pick = GNT_D;
    end else if (if_req) begin
      pick = GNT_IF;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported, variable-latency memory between instruction
// fetch and load/store. One access at a time: IDLE picks a winner and latches
// its fields, GNT holds mem_req until mem_ready, ACK pulses the winner's ack.
// Optional build macro: MEM_ARB_RR_EN (round-robin tie-break instead of
// fixed data-over-fetch priority).
//
// Handshakes: requesters hold their request (and its fields) until their
// one-cycle ack; the memory side holds mem_req with stable address/data/we
// until it answers with mem_ready, and mem_ready is ignored when no grant is
// active. A requester dropping its request mid-grant does not abort it.
module mem_port_arbiter
  import cpu_arb_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_req,
  input  logic [WIDTH-1:0] if_addr,
  output logic [WIDTH-1:0] if_rdata,
  output logic             if_ack,
  input  logic             d_read_en,
  input  logic             d_write_en,
  input  logic [WIDTH-1:0] d_addr,
  input  logic [WIDTH-1:0] d_wdata,
  output logic [WIDTH-1:0] d_rdata,
  output logic             d_ack,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ready,
  output logic             stall,
  output arb_state_t       dbg_state
);

  arb_state_t state;
  arb_state_t state_nxt;
  gnt_t       pick;
  logic       d_req;
  logic       take;

  assign d_req = d_read_en | d_write_en;
  assign take  = (state == ST_IDLE) && (pick != GNT_NONE);

  mem_arb_pick u_pick (
    .clk    (clk),
    .rst_n  (rst),
    .if_req (if_req),
    .d_req  (d_req),
    .take   (take),
    .pick   (pick)
  );

  // Next-state: one grant at a time, always followed by a single ACK cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (pick == GNT_D) begin
          state_nxt = ST_GNT_D;
        end else if (pick == GNT_IF) begin
          state_nxt = ST_GNT_IF;
        end
      end
      ST_GNT_IF, ST_GNT_D: begin
        if (mem_ready) begin
          state_nxt = ST_ACK;
        end
      end
      ST_ACK: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Registered memory-side fields, read data capture and ack pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      if_ack    <= 1'b0;
      d_ack     <= 1'b0;
    end else begin
      if_ack  <= 1'b0;
      d_ack   <= 1'b0;
      mem_req <= (state_nxt == ST_GNT_IF) || (state_nxt == ST_GNT_D);
      if (take) begin
        if (pick == GNT_D) begin
          mem_addr  <= d_addr;
          mem_wdata <= d_wdata;
          mem_we    <= d_write_en;
        end else begin
          mem_addr  <= if_addr;
          mem_wdata <= '0;
          mem_we    <= 1'b0;
        end
      end
      if (state == ST_GNT_IF && mem_ready) begin
        if_rdata <= mem_rdata;
        if_ack   <= 1'b1;
      end
      if (state == ST_GNT_D && mem_ready) begin
        // A store leaves the load-data register untouched.
        if (!mem_we) begin
          d_rdata <= mem_rdata;
        end
        d_ack <= 1'b1;
      end
    end
  end

  assign stall     = (if_req & ~if_ack) | (d_req & ~d_ack);
  assign dbg_state = state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios followed by randomized
// rounds, checked against a transaction-level model (expected grant order,
// memory contents, ack timing derived from the memory's ready cycle).
module tb_mem_port_arbiter;
  import cpu_arb_pkg::*;

  localparam int W = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         if_req, d_read_en, d_write_en, mem_ready;
  logic [W-1:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic [W-1:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic         if_ack, d_ack, mem_req, mem_we, stall;
  arb_state_t   dbg_state;

  mem_port_arbiter #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst_n),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_rdata   (if_rdata),
    .if_ack     (if_ack),
    .d_read_en  (d_read_en),
    .d_write_en (d_write_en),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_rdata    (d_rdata),
    .d_ack      (d_ack),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .stall      (stall),
    .dbg_state  (dbg_state)
  );

  // ---------------- scoreboard / model ----------------
  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_wd_q[$];
  bit           exp_we_q[$];
  bit           exp_who_q[$];   // 0 = fetch, 1 = data
  int           exp_w_q[$];     // wait states for that access

  logic [W-1:0] mem_model[logic [W-1:0]];
  logic [W-1:0] exp_if_rdata;
  logic [W-1:0] exp_d_rdata;
  bit           last_was_d;     // who the model granted most recently
  bit           wig_en;
  bit           drop_en;

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] mem_val(input logic [W-1:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return (a * 32'd2654435761) ^ 32'h5a5a_0000;
  endfunction

  function automatic bit prefer_d();
`ifdef MEM_ARB_RR_EN
    return !last_was_d;
`else
    return 1'b1;
`endif
  endfunction

  task automatic push(input logic [W-1:0] a, input bit we, input logic [W-1:0] wd,
                      input bit who, input int w);
    exp_q.push_back(a);
    exp_we_q.push_back(we);
    exp_wd_q.push_back(wd);
    exp_who_q.push_back(who);
    exp_w_q.push_back(w);
    last_was_d = who;
  endtask

  task automatic model_reset();
    exp_if_rdata = '0;
    exp_d_rdata  = '0;
    last_was_d   = 1'b0;
  endtask

  // ---------------- engine: plays the memory and checks every cycle ----------------
  task automatic engine();
    int cyc, next_gnt, gcyc, w;
    bit in_gnt, ack_now, ack_who, g_we, g_who, e_if_ack, e_d_ack, e_stall;
    logic [W-1:0] g_addr, g_wd, resp;
    cyc = 0; next_gnt = 1; gcyc = 0; w = 0;
    in_gnt = 0; ack_now = 0; ack_who = 0; g_we = 0; g_who = 0;
    g_addr = '0; g_wd = '0; resp = '0;
    while ((exp_q.size() != 0 || in_gnt || ack_now) && cyc < 80) begin
      @(negedge clk);
      cyc++;
      e_if_ack = ack_now && !ack_who;
      e_d_ack  = ack_now && ack_who;
      e_stall  = (if_req && !e_if_ack) || ((d_read_en || d_write_en) && !e_d_ack);
      check_eq("if_ack", W'(if_ack), W'(e_if_ack));
      check_eq("d_ack", W'(d_ack), W'(e_d_ack));
      check_eq("stall", W'(stall), W'(e_stall));
      if (ack_now) begin
        if (ack_who) begin
          check_eq("d_rdata", d_rdata, exp_d_rdata);
          d_read_en = 1'b0; d_write_en = 1'b0;
        end else begin
          check_eq("if_rdata", if_rdata, exp_if_rdata);
          if_req = 1'b0;
        end
        ack_now  = 0;
        next_gnt = cyc + 2;
      end else if (!in_gnt && exp_q.size() != 0 && cyc == next_gnt) begin
        g_addr = exp_q.pop_front();
        g_we   = exp_we_q.pop_front();
        g_wd   = exp_wd_q.pop_front();
        g_who  = exp_who_q.pop_front();
        w      = exp_w_q.pop_front();
        in_gnt = 1; gcyc = 0;
      end
      check_eq("mem_req", W'(mem_req), W'(in_gnt));
      if (in_gnt) begin
        check_eq("mem_addr", mem_addr, g_addr);
        check_eq("mem_we", W'(mem_we), W'(g_we));
        if (g_we) check_eq("mem_wdata", mem_wdata, g_wd);
        if (gcyc == w) begin
          resp = g_we ? W'($urandom) : mem_val(g_addr);
          if (g_we) mem_model[g_addr] = g_wd;
          else if (g_who) exp_d_rdata = resp;
          else exp_if_rdata = resp;
          mem_ready = 1'b1; mem_rdata = resp;
          in_gnt = 0; ack_now = 1; ack_who = g_who;
        end else begin
          mem_ready = 1'b0; mem_rdata = W'($urandom);
        end
        if (gcyc == 0 && wig_en) begin
          if (g_who) begin d_addr = d_addr + 4; d_wdata = ~d_wdata; end
          else if_addr = if_addr + 4;
        end
        if (gcyc == 0 && drop_en) begin
          if (g_who) begin d_read_en = 1'b0; d_write_en = 1'b0; end
          else if_req = 1'b0;
        end
        gcyc++;
      end else begin
        // ready outside a grant must be ignored
        mem_ready = 1'($urandom_range(0, 1));
        mem_rdata = W'($urandom);
      end
    end
    check_eq("pending_at_end", W'(exp_q.size() + int'(in_gnt) + int'(ack_now)), '0);
    exp_q.delete(); exp_we_q.delete(); exp_wd_q.delete(); exp_who_q.delete(); exp_w_q.delete();
    @(negedge clk);
    check_eq("idle_req", W'(mem_req), '0);
    check_eq("idle_if_ack", W'(if_ack), '0);
    check_eq("idle_d_ack", W'(d_ack), '0);
    check_eq("idle_stall", W'(stall), '0);
    mem_ready = 1'b0;
  endtask

  // ---------------- driver ----------------
  task automatic run_round(input bit use_if, input bit use_d, input bit wr, input bit rd,
                           input logic [W-1:0] ia, input logic [W-1:0] da,
                           input logic [W-1:0] dw, input int w_if, input int w_d,
                           input bit wig, input bit drp);
    bit d_first;
    @(negedge clk);
    if_req     = use_if;
    if_addr    = ia;
    d_read_en  = use_d && rd;
    d_write_en = use_d && wr;
    d_addr     = da;
    d_wdata    = dw;
    mem_ready  = 1'($urandom_range(0, 1));
    wig_en     = wig;
    drop_en    = drp;
    d_first    = use_d && (!use_if || prefer_d());
    if (d_first) begin
      push(da, wr, dw, 1'b1, w_d);
      if (use_if) push(ia, 1'b0, '0, 1'b0, w_if);
    end else begin
      push(ia, 1'b0, '0, 1'b0, w_if);
      if (use_d) push(da, wr, dw, 1'b1, w_d);
    end
    engine();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    if_req = 0; d_read_en = 0; d_write_en = 0; mem_ready = 0;
    if_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
    wig_en = 0; drop_en = 0;
    model_reset();

    repeat (2) @(negedge clk);
    mem_ready = 1'b1;
    @(negedge clk);
    check_eq("rst_state", W'(dbg_state), W'(ST_IDLE));
    check_eq("rst_mem_req", W'(mem_req), '0);
    check_eq("rst_mem_we", W'(mem_we), '0);
    check_eq("rst_if_ack", W'(if_ack), '0);
    check_eq("rst_d_ack", W'(d_ack), '0);
    check_eq("rst_mem_addr", mem_addr, '0);
    check_eq("rst_mem_wdata", mem_wdata, '0);
    check_eq("rst_if_rdata", if_rdata, '0);
    check_eq("rst_d_rdata", d_rdata, '0);
    check_eq("rst_stall", W'(stall), '0);
    mem_ready = 1'b0;
    rst_n = 1'b1;

    // reset in the middle of a data grant, with a fetch waiting
    @(negedge clk);
    d_write_en = 1; d_addr = 32'h200; d_wdata = 32'hCAFE_F00D;
    if_req = 1; if_addr = 32'h80;
    @(negedge clk);
    check_eq("rg_mem_req", W'(mem_req), W'(1));
    check_eq("rg_mem_addr", mem_addr, 32'h200);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rg_req_drop", W'(mem_req), '0);
    check_eq("rg_d_ack", W'(d_ack), '0);
    check_eq("rg_state", W'(dbg_state), W'(ST_IDLE));
    @(negedge clk);
    d_write_en = 0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    mem_ready = 1'b0;
    wig_en = 0; drop_en = 0;
    push(32'h80, 1'b0, '0, 1'b0, 1);
    engine();

    // fetch only, zero-wait memory
    mem_model[32'h40] = 32'h8C02_0004;
    run_round(1, 0, 0, 0, 32'h40, '0, '0, 0, 0, 0, 0);
    // store with two wait states
    run_round(0, 1, 1, 0, '0, 32'h100, 32'hDEAD_BEEF, 0, 2, 0, 0);
    // simultaneous fetch and load, twice
    run_round(1, 1, 0, 1, 32'h40, 32'h100, '0, 1, 0, 0, 0);
    run_round(1, 1, 0, 1, 32'h44, 32'h104, '0, 0, 1, 0, 0);
    // fetch address moves 0x40 -> 0x44 mid-grant
    run_round(1, 0, 0, 0, 32'h40, '0, '0, 2, 0, 1, 0);
    // read and write enables together act as a store
    run_round(0, 1, 1, 1, '0, 32'h108, 32'h1234_5678, 0, 1, 0, 0);
    // fetch dropped while granted still completes
    run_round(1, 0, 0, 0, 32'h48, '0, '0, 2, 0, 0, 1);

    for (int r = 0; r < 40; r++) begin
      int sc, k;
      logic [W-1:0] ia, da, dw;
      sc = $urandom_range(0, 4);
      k  = $urandom_range(0, 2);
      ia = 32'h1000 + (W'($urandom_range(0, 15)) << 2);
      da = 32'h1000 + (W'($urandom_range(0, 15)) << 2);
      dw = W'($urandom);
      case (sc)
        0: run_round(1, 0, 0, 0, ia, da, dw, $urandom_range(0, 3), 0,
                     1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0);
        1: run_round(0, 1, 0, 1, ia, da, dw, 0, $urandom_range(0, 3),
                     1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0);
        2: run_round(0, 1, 1, 0, ia, da, dw, 0, $urandom_range(0, 3),
                     1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0);
        3: run_round(0, 1, 1, 1, ia, da, dw, 0, $urandom_range(0, 3),
                     1'($urandom_range(0, 1)), 0);
        default: run_round(1, 1, k != 0, k != 1, ia, da, dw, $urandom_range(0, 3),
                           $urandom_range(0, 3), 1'($urandom_range(0, 1)), 0);
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // hard stop if something wedges the run
  initial begin
    #500000;
    $display("FAIL watchdog: run did not complete, %0d tests so far", n_tests);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-ported, variable-latency memory between the pipeline's instruction-fetch port and its load/store port. A small FSM grants one requester at a time, holds the memory request until the memory signals ready, and returns registered read data with a one-cycle acknowledge. It drives a stall signal that freezes the pipeline registers while any access is outstanding. It sits between the CPU core and the unified memory model.

## Interface
Parameters:
- `WIDTH`, 32: address and data width.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `if_req`  in  1  fetch request; held until `if_ack`.
- `if_addr`  in  WIDTH  fetch address.
- `if_rdata`  out  WIDTH  fetched instruction; valid while `if_ack`.
- `if_ack`  out  1  one-cycle fetch completion pulse.
- `d_read_en`  in  1  load request; held until `d_ack`.
- `d_write_en`  in  1  store request; held until `d_ack`.
- `d_addr`  in  WIDTH  data address.
- `d_wdata`  in  WIDTH  store data.
- `d_rdata`  out  WIDTH  load data; valid while `d_ack`.
- `d_ack`  out  1  one-cycle data completion pulse.
- `mem_req`  out  1  memory request.
- `mem_we`  out  1  memory write enable; qualified by `mem_req`.
- `mem_addr`  out  WIDTH  memory address.
- `mem_wdata`  out  WIDTH  memory write data.
- `mem_rdata`  in  WIDTH  memory read data; sampled when `mem_ready`.
- `mem_ready`  in  1  memory completion; meaningful only while `mem_req`.
- `stall`  out  1  pipeline freeze.

## Operation
- FSM states: IDLE, GNT_IF, GNT_D, ACK.
- IDLE: `d_req = d_read_en | d_write_en`. If `d_req`, go to GNT_D; else if `if_req`, go to GNT_IF. Latch the address, write data and `mem_we` (= `d_write_en`) of the winner into registers.
- GNT_IF / GNT_D: `mem_req`=1 with the latched fields. They are stable for the whole grant, regardless of requester input changes. On `mem_ready`=1, capture `mem_rdata` into the winner's rdata register, then go to ACK.
- ACK: assert the winner's ack for exactly one cycle, with no new grant. Then go to IDLE.
- Stores: `d_rdata` holds its previous value; `d_ack` is still pulsed.
- `d_read_en` and `d_write_en` both high: treated as a store.
- `stall` = (`if_req` & ~`if_ack`) | (`d_req` & ~`d_ack`), combinational.
- Reset values: state IDLE; `mem_req`, `mem_we`, `if_ack`, `d_ack` = 0; `mem_addr`, `mem_wdata`, `if_rdata`, `d_rdata` = 0; round-robin pointer favours data.

## Timing
- All outputs except `stall` are registered.
- Request seen in IDLE at edge N → `mem_req` high after edge N.
- `mem_ready` high at edge M → ack high for cycle M+1 only.
- Zero-wait memory (`mem_ready` tied 1) gives 3 cycles per access: IDLE, GNT, ACK.
- Wait states extend the GNT state indefinitely. There is no timeout.
- A requester that drops its request while granted does not abort the access. The access completes and the ack is still pulsed.
- Asynchronous reset mid-grant: `mem_req` falls immediately and the transfer is abandoned. After release, the FSM restarts from IDLE.
- `mem_ready` outside a grant is ignored.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin arbitration. On a simultaneous fetch and data request in IDLE, the requester not granted last wins. The pointer updates on every grant.
- `MEM_ARB_RR_EN` undefined: fixed priority, data over fetch. The pointer logic is not compiled.

## Structure
- Shared package `cpu_arb_pkg`: FSM state enum; grant encoding `GNT_NONE`/`GNT_IF`/`GNT_D`.
- One sub-module, `mem_arb_pick`: combinational winner selection from the two requests and the round-robin pointer, with the pointer register under `MEM_ARB_RR_EN`.
- The top module holds the FSM, the latches and `stall`.

## Test plan
- Fetch only: `if_addr`=0x40, `mem_ready`=1, `mem_rdata`=0x8C020004 → `mem_req` for 1 cycle at addr 0x40 with `mem_we`=0; `if_ack` 3 cycles after the request with `if_rdata`=0x8C020004; `stall` high until the ack.
- Store with 2 wait states: `d_write_en`, `d_addr`=0x100, `d_wdata`=0xDEADBEEF → `mem_req`/`mem_we` high for 3 cycles with stable addr and data; `d_ack` one cycle after `mem_ready`; `d_rdata` unchanged.
- Simultaneous fetch and load, fixed priority → data granted first, fetch granted on the next IDLE. With `MEM_ARB_RR_EN`: second simultaneous pair → fetch wins.
- Reset asserted in the middle of GNT_D → `mem_req`=0 within the same cycle, no ack; after release, a pending `if_req` is served normally.
- Change `if_addr` from 0x40 to 0x44 mid-grant → `mem_addr` stays 0x40; exactly one `if_ack`.
- Both `d_read_en` and `d_write_en` high → `mem_we`=1.
